data_bus_responder: RTL
=======================

Name: data_bus_responder

Overview:
- Responder (target) end of the core's data-memory load/store handshake.
- Accepts one request at a time from the core, inserts programmable wait states, and serves it from one of two places:
  - the external synchronous data RAM (same address/clock/data/wren/q style as the data memory);
  - a small memory-mapped I/O (MMIO) register file.
- Returns a one-cycle acknowledge with read data.
- Sits between the core datapath and the data memory. It replaces direct RAM wiring so that I/O (LEDs, cycle counter) is reachable by ordinary loads and stores.

Parameters:
- ADDR_W, 18, request word-address width; bit ADDR_W-1 selects MMIO (1) or RAM (0)
- DATA_W, 32, data width
- WAIT_STATES, 1, extra idle cycles inserted before every access (0..15)
- LED_W, 8, width of the LED output register

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  core request; held high, with addr/we/wdata stable, until ack
- we  in  1  1 = store, 0 = load
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  store data
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  load data, valid only while ack=1, else 0
- err  out  1  with ack: access hit an unmapped MMIO offset
- mem_address  out  ADDR_W-1  RAM address
- mem_data  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data (one cycle after address sampled)
- led_out  out  LED_W  LED register contents

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; ack, err, mem_wren = 0; rdata = 0.
  - led_out = 0, cycle counter = 0, sticky error = 0.
  - mem_address and mem_data = 0.
- States:
  - IDLE: if req=1, latch addr/we/wdata and load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: decrement the counter; when it reaches 1, go to ACCESS.
  - ACCESS: one cycle. For RAM, drive mem_address and mem_data from the latches, with mem_wren=we. For MMIO, perform the register write and capture the read value. Always go to RESP.
  - RESP: ack=1. rdata is mem_q for a RAM load, the captured MMIO value for an MMIO load, and 0 for any store. err=1 if the MMIO offset was unmapped. Always go to IDLE.
- Latency: req first seen high in IDLE at cycle N gives ack in cycle N+2+WAIT_STATES.
- mem_wren is high for exactly one cycle per RAM store, and never for an MMIO access.
- After ack the core must drop req or present a new request. Because IDLE samples req, back-to-back transactions cost one IDLE cycle each.
- MMIO map (offset = addr[3:0], bits ADDR_W-2..4 ignored):
  - 0x0 LED: RW. A write loads led_out <= wdata[LED_W-1:0]; a read returns the value zero-extended.
  - 0x1 CYCLE: free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0. A write loads wdata; in that cycle the write wins over the increment, and the next cycle continues from wdata+1.
  - 0x2 STATUS: RO, bit0 = sticky error. A read returns the flag and then clears it. If an error sets the flag in the same cycle as a read clears it, set wins. A write to STATUS is ignored and is not an error.
  - Other offsets: a read returns 0, a write is ignored, err=1 with ack, and the sticky error flag is set.
- The counter increments in every state, including reset release. During rst it stays at 0.
- req changes outside IDLE are ignored; the latched values are used throughout.
- Reset mid-transaction: immediate return to IDLE with no ack and no mem_wren. An in-flight store is dropped.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, ACCESS, RESP), MMIO offset constants (MMIO_LED=0, MMIO_CYCLE=1, MMIO_STATUS=2), and the MMIO select bit position.
- One sub-module, mmio_regs, holds the LED register, cycle counter and sticky error. Its interface is write strobe, read strobe, offset, wdata, rdata and unmapped flag.
- The handshake FSM and wait counter stay in the top module.

Test Plan:
- Reset, then store to RAM 0x00010 with 0xDEADBEEF, WAIT_STATES=1 -> mem_wren high for one cycle with mem_address=0x00010 and mem_data=0xDEADBEEF; ack at N+3.
- Load RAM 0x00010, with the RAM model returning 0xDEADBEEF -> ack at N+3, rdata=0xDEADBEEF, err=0; rdata=0 in the cycles before and after.
- Store 0x000000A5 to MMIO LED (addr 0x20000) -> led_out=0xA5, mem_wren never asserted; then load 0x20000 -> rdata=0x000000A5.
- Store 0xFFFFFFFE to CYCLE (addr 0x20001), then load CYCLE -> value consistent with wrap through 0xFFFFFFFF -> 0x00000000 and the elapsed-cycle count.
- Load from unmapped offset 0x20007 -> ack with err=1 and rdata=0; then load STATUS (0x20002) -> rdata=1; then load STATUS again -> rdata=0.
- Start a store with WAIT_STATES=3 and assert rst during WAIT -> no mem_wren, no ack, state IDLE. The next request completes normally.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data bus responder: FSM states, the MMIO
// register map and the location of the RAM/MMIO select bit.
package data_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int MMIO_OFF_W = 4;

    localparam logic [MMIO_OFF_W-1:0] MMIO_LED    = 4'h0;
    localparam logic [MMIO_OFF_W-1:0] MMIO_CYCLE  = 4'h1;
    localparam logic [MMIO_OFF_W-1:0] MMIO_STATUS = 4'h2;

    // The top address bit steers a request to MMIO (1) or RAM (0)
    function automatic int mmio_sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/data_bus_responder_mmio_regs.sv
// Memory-mapped I/O register file: LED register, free-running cycle
// counter and a read-to-clear sticky error flag for unmapped accesses.
import data_bus_responder_pkg::*;

module mmio_regs #(
    parameter int DATA_W = 32,
    parameter int LED_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [MMIO_OFF_W-1:0] offset,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  unmapped,
    output logic [LED_W-1:0]      led_out
);

    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;
    logic             sticky_q;

    assign led_out = led_q;

    // Decode the offset into read data and a flag for holes in the map
    always_comb begin
        rdata    = '0;
        unmapped = 1'b1;
        case (offset)
            MMIO_LED: begin
                rdata    = DATA_W'(led_q);
                unmapped = 1'b0;
            end
            MMIO_CYCLE: begin
                rdata    = DATA_W'(cycle_q);
                unmapped = 1'b0;
            end
            MMIO_STATUS: begin
                rdata    = DATA_W'(sticky_q);
                unmapped = 1'b0;
            end
            default: begin
                rdata    = '0;
                unmapped = 1'b1;
            end
        endcase
    end

    // Register updates: a CYCLE write overrides the increment, and a new
    // error takes priority over the clear caused by reading STATUS
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            cycle_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (wr_en && offset == MMIO_CYCLE) begin
                cycle_q <= 32'(wdata);
            end else begin
                cycle_q <= cycle_q + 32'd1;
            end

            if (wr_en && offset == MMIO_LED) begin
                led_q <= wdata[LED_W-1:0];
            end

            if ((wr_en || rd_en) && unmapped) begin
                sticky_q <= 1'b1;
            end else if (rd_en && offset == MMIO_STATUS) begin
                sticky_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Target end of the core's data load/store handshake. Accepts one request
// at a time, inserts WAIT_STATES idle cycles, then serves it from the
// external synchronous RAM or from the MMIO register file.
import data_bus_responder_pkg::*;

module data_bus_responder #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int LED_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-2:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [LED_W-1:0]  led_out
);

    localparam int SEL_BIT = mmio_sel_bit(ADDR_W);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mmio_rdata_q;
    logic              ack_q;
    logic              err_q;

    logic              is_mmio;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [DATA_W-1:0] mmio_rdata;
    logic              mmio_unmapped;

    assign is_mmio = addr_q[SEL_BIT];
    assign mmio_wr = (state == ACCESS) && is_mmio && we_q;
    assign mmio_rd = (state == ACCESS) && is_mmio && !we_q;

    // RAM is driven straight from the request latches; the write enable is
    // confined to the single ACCESS cycle of a RAM store
    assign mem_address = addr_q[ADDR_W-2:0];
    assign mem_data    = wdata_q;
    assign mem_wren    = (state == ACCESS) && we_q && !is_mmio;

    assign ack = ack_q;
    assign err = err_q;

    mmio_regs #(
        .DATA_W (DATA_W),
        .LED_W  (LED_W)
    ) u_mmio_regs (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mmio_wr),
        .rd_en    (mmio_rd),
        .offset   (addr_q[MMIO_OFF_W-1:0]),
        .wdata    (wdata_q),
        .rdata    (mmio_rdata),
        .unmapped (mmio_unmapped),
        .led_out  (led_out)
    );

    // Handshake FSM with wait-state counter; ack and err are registered so
    // they are high exactly for the RESP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mmio_rdata_q <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= addr;
                        we_q     <= we;
                        wdata_q  <= wdata;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mmio_rdata_q <= mmio_rdata;
                    ack_q        <= 1'b1;
                    err_q        <= is_mmio && mmio_unmapped;
                    state        <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load data is only presented alongside ack; RAM data arrives from the
    // synchronous RAM one cycle after ACCESS, i.e. during RESP
    always_comb begin
        rdata = '0;
        if (ack_q && !we_q) begin
            rdata = is_mmio ? mmio_rdata_q : mem_q;
        end
    end

endmodule
